// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory access stage: alignment check, big-endian lane steering and load extension.
// Optional bus-timeout abort is compiled in when DMEM_TIMEOUT_EN is defined.
module data_mem_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_cs,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("data_mem_ctrl: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REQ, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        rw_q, sext_q;
  logic        err_q, err_d;
  logic [1:0]  size_q, off_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic        accept, misaligned, timeout_hit;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, load_val;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign accept = (state_q == S_IDLE) && start;

  // Lane steering is computed from the live inputs so it can be latched on the accepting edge.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    be_new    = 4'b0000;
    wdata_new = wdata;
    case (size)
      2'b00: begin
        be_new    = 4'b1000 >> addr[1:0];
        wdata_new = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_new    = addr[1] ? 4'b0011 : 4'b1100;
        wdata_new = {2{wdata[15:0]}};
      end
      2'b10:   be_new = 4'b1111;
      default: be_new = 4'b0000;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off_q[0];
      2'b10:   misaligned = (off_q != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Big-endian: byte offset 0 lives in bits 31:24.
  always_comb begin
    case (off_q)
      2'b00:   rd_byte = mem_rdata[31:24];
      2'b01:   rd_byte = mem_rdata[23:16];
      2'b10:   rd_byte = mem_rdata[15:8];
      default: rd_byte = mem_rdata[7:0];
    endcase
    rd_half = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (size_q)
      2'b00:   load_val = {{24{sext_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_val = {{16{sext_q & rd_half[15]}}, rd_half};
      default: load_val = mem_rdata;
    endcase
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] timer_q;

  assign timeout_hit = (timer_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                            timer_q <= '0;
    else if (state_q == S_CHECK)                           timer_q <= '0;
    else if (state_q == S_REQ && !mem_ack && !timeout_hit) timer_q <= timer_q + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_CHECK;
        err_d   = 1'b0;
      end
      S_CHECK: begin
        state_d = misaligned ? S_DONE : S_REQ;
        err_d   = misaligned;
      end
      // An ack in the final timer cycle still completes cleanly.
      S_REQ: if (mem_ack) begin
        state_d = S_DONE;
        if (!rw_q) rdata_d = load_val;
      end else if (timeout_hit) begin
        state_d = S_DONE;
        err_d   = 1'b1;
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q     <= S_IDLE;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      rw_q        <= 1'b0;
      sext_q      <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (accept) begin
        rw_q        <= rw;
        sext_q      <= sign_ext;
        size_q      <= size;
        off_q       <= addr[1:0];
        mem_addr_q  <= {addr[31:2], 2'b00};
        mem_be_q    <= be_new;
        mem_wdata_q <= wdata_new;
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_cs    = (state_q == S_REQ);
  assign mem_wr    = mem_cs & rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: spec-level timeline model checked every cycle plus
// directed accesses with literal expectations. Follows DMEM_TIMEOUT_EN like the design.
`timescale 1ns/1ps
module tb_data_mem_ctrl;
  localparam int TO = 15;

  logic        clk = 1'b0, reset = 1'b0;
  logic        start = 1'b0, rw = 1'b0, sign_ext = 1'b0, mem_ack = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
  logic        busy, done, err, mem_cs, mem_wr;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- spec-level model ----------------
  function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << (3 - off);
      2'b01:   return off[1] ? 4'b0011 : 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_wd(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {24'b0, d[7:0]} * 32'h0101_0101;
      2'b01:   return {16'b0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [1:0] sz, input logic [1:0] off,
                                         input logic sx, input logic [31:0] w);
    logic [31:0] v;
    case (sz)
      2'b00: begin
        v = (w >> (8 * (3 - off))) & 32'h0000_00FF;
        if (sx && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'b01: begin
        v = (w >> (16 * (1 - off[1]))) & 32'h0000_FFFF;
        if (sx && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic bit f_mis(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'b11) || (sz == 2'b01 && off[0]) || (sz == 2'b10 && off != 2'b00);
  endfunction

  bit          m_active = 0, m_req = 0, m_done = 0, m_err = 0, m_rw = 0, m_sx = 0;
  logic [1:0]  m_sz = '0, m_off = '0;
  logic [31:0] m_rdata = '0, m_maddr = '0, m_wd = '0;
  logic [3:0]  m_be = '0;
  int          m_wait = 0;
`ifdef DMEM_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 0; m_req = 0; m_done = 0; m_err = 0; m_rdata = '0;
    end else if (m_done) begin
      m_done = 0; m_active = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_err = 0; m_rw = rw; m_sz = size; m_off = addr[1:0]; m_sx = sign_ext;
        m_maddr = addr & 32'hFFFF_FFFC; m_be = f_be(size, addr[1:0]); m_wd = f_wd(size, wdata);
      end
    end else if (!m_req) begin
      if (f_mis(m_sz, m_off)) begin m_done = 1; m_err = 1; end
      else begin m_req = 1; m_wait = 0; end
    end else if (mem_ack) begin
      m_req = 0; m_done = 1;
      if (!m_rw) m_rdata = f_load(m_sz, m_off, m_sx, mem_rdata);
    end else begin
      m_wait++;
      if (TIMEOUT_ON && m_wait == TO) begin m_req = 0; m_done = 1; m_err = 1; end
    end
  end

  always @(negedge clk) begin
    check("busy",   32'(busy),   32'(m_active));
    check("done",   32'(done),   32'(m_done));
    check("err",    32'(err),    32'(m_err));
    check("rdata",  rdata,       m_rdata);
    check("mem_cs", 32'(mem_cs), 32'(m_req));
    check("mem_wr", 32'(mem_wr), 32'(m_req && m_rw));
    if (m_req) begin
      check("mem_addr",  mem_addr,      m_maddr);
      check("mem_be",    32'(mem_be),   32'(m_be));
      check("mem_wdata", mem_wdata,     m_wd);
    end
  end

  // ---------------- directed driver ----------------
  task automatic access(input bit w, input logic [1:0] sz, input bit sx, input logic [31:0] a,
                        input logic [31:0] d, input int ack_at, input logic [31:0] rd,
                        input bit poke, output int lat, output int cs_n,
                        output logic [3:0] be_seen, output logic [31:0] wd_seen, output bit wr_seen);
    bit fin;
    fin = 0; lat = 0; cs_n = 0; be_seen = '0; wd_seen = '0; wr_seen = 0;
    @(negedge clk); #1;
    start = 1; rw = w; size = sz; sign_ext = sx; addr = a; wdata = d; mem_rdata = rd;
    @(posedge clk);
    for (int c = 1; c <= 200 && !fin; c++) begin
      @(negedge clk);
      lat = c;
      fin = done;
      if (mem_cs) begin
        cs_n++;
        if (cs_n == 1) begin be_seen = mem_be; wd_seen = mem_wdata; wr_seen = mem_wr; end
      end
      #1;
      // Inputs are scrambled after acceptance; a stray start during REQ must be ignored.
      start    = poke && mem_cs && cs_n == 1;
      rw       = ~w; size = ~sz; sign_ext = ~sx; addr = ~a; wdata = ~d;
      mem_ack  = !fin && mem_cs && ack_at >= 0 && cs_n == ack_at + 1;
    end
    if (!fin) check("done_within_budget", 32'd0, 32'd1);
    start = 0; mem_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, cs_n;
    logic [3:0]  be_s;
    logic [31:0] wd_s;
    bit          wr_s;
    logic [31:0] exp_b [3];
    exp_b = '{32'h11, 32'h22, 32'h33};

    repeat (2) @(negedge clk);
    check("rst_busy",      32'(busy),   32'd0);
    check("rst_mem_addr",  mem_addr,    32'd0);
    check("rst_mem_be",    32'(mem_be), 32'd0);
    check("rst_mem_wdata", mem_wdata,   32'd0);
    check("rst_rdata",     rdata,       32'd0);
    #1 reset = 1;

    // lw with ack on the third REQ cycle
    access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, lat, cs_n, be_s, wd_s, wr_s);
    check("lw_lat", 32'(lat), 32'd5);
    check("lw_cs_cycles", 32'(cs_n), 32'd3);
    check("lw_be", 32'(be_s), 32'hF);
    check("lw_rdata", rdata, 32'hDEAD_BEEF);
    check("lw_err", 32'(err), 32'd0);

    // lb / lbu at offset 3, minimum latency
    access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 32'h0000_00F0, 1'b0, lat, cs_n, be_s, wd_s, wr_s);
    check("lb_lat", 32'(lat), 32'd3);
    check("lb_be", 32'(be_s), 32'h1);
    check("lb_rdata", rdata, 32'hFFFF_FFF0);
    access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 32'h0000_00F0, 1'b0, lat, cs_n, be_s, wd_s, wr_s);
    check("lbu_rdata", rdata, 32'h0000_00F0);

    // sh at offset 2: rdata untouched
    access(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234_ABCD, 1, 32'h5555_5555, 1'b0, lat, cs_n, be_s, wd_s, wr_s);
    check("sh_be", 32'(be_s), 32'h3);
    check("sh_wdata", wd_s, 32'hABCD_ABCD);
    check("sh_wr", 32'(wr_s), 32'd1);
    check("sh_rdata_kept", rdata, 32'h0000_00F0);

    // sb at offset 1
    access(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00A5, 0, 32'h0, 1'b0, lat, cs_n, be_s, wd_s, wr_s);
    check("sb_be", 32'(be_s), 32'h4);
    check("sb_wdata", wd_s, 32'hA5A5_A5A5);

    // lbu at offsets 0..2
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 2'b00, 1'b0, 32'h200 + 32'(i), 32'h0, 0, 32'h1122_3344, 1'b0, lat, cs_n, be_s, wd_s, wr_s);
      check("lbu_lane", rdata, exp_b[i]);
    end

    // misaligned accesses: no memory cycle, err at done
    access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 0, 32'h0, 1'b0, lat, cs_n, be_s, wd_s, wr_s);
    check("mis_lw_lat", 32'(lat), 32'd2);
    check("mis_lw_cs", 32'(cs_n), 32'd0);
    check("mis_lw_err", 32'(err), 32'd1);
    access(1'b0, 2'b01, 1'b1, 32'h103, 32'h0, 0, 32'h0, 1'b0, lat, cs_n, be_s, wd_s, wr_s);
    check("mis_lh_err", 32'(err), 32'd1);
    access(1'b1, 2'b11, 1'b0, 32'h100, 32'h0, 0, 32'h0, 1'b0, lat, cs_n, be_s, wd_s, wr_s);
    check("mis_size3_cs", 32'(cs_n), 32'd0);
    check("mis_size3_err", 32'(err), 32'd1);
    // next valid access clears err; lh sign at offset 2
    access(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 0, 32'h0000_8001, 1'b0, lat, cs_n, be_s, wd_s, wr_s);
    check("lh_err_cleared", 32'(err), 32'd0);
    check("lh_rdata", rdata, 32'hFFFF_8001);

`ifdef DMEM_TIMEOUT_EN
    access(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, -1, 32'h0, 1'b0, lat, cs_n, be_s, wd_s, wr_s);
    check("to_cs_cycles", 32'(cs_n), 32'(TO));
    check("to_lat", 32'(lat), 32'(TO + 2));
    check("to_err", 32'(err), 32'd1);
    access(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, TO - 1, 32'hCAFE_F00D, 1'b0, lat, cs_n, be_s, wd_s, wr_s);
    check("to_last_ack_err", 32'(err), 32'd0);
    check("to_last_ack_rdata", rdata, 32'hCAFE_F00D);
`else
    access(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 20, 32'hCAFE_F00D, 1'b0, lat, cs_n, be_s, wd_s, wr_s);
    check("long_wait_lat", 32'(lat), 32'd23);
    check("long_wait_err", 32'(err), 32'd0);
    check("long_wait_rdata", rdata, 32'hCAFE_F00D);
`endif

    // start while busy is ignored
    access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1, 32'h0BAD_F00D, 1'b1, lat, cs_n, be_s, wd_s, wr_s);
    check("poke_cs_cycles", 32'(cs_n), 32'd2);
    repeat (3) @(negedge clk);
    check("poke_no_second", 32'(busy), 32'd0);

    // asynchronous reset during REQ
    #1 start = 1; rw = 1'b0; size = 2'b10; addr = 32'h300;
    @(negedge clk); #1 start = 0;
    @(negedge clk);
    check("pre_reset_cs", 32'(mem_cs), 32'd1);
    #2 reset = 0;
    #1;
    check("async_cs",    32'(mem_cs), 32'd0);
    check("async_busy",  32'(busy),   32'd0);
    check("async_rdata", rdata,       32'd0);
    @(negedge clk); #1 reset = 1;

    access(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 0, 32'h0102_0304, 1'b0, lat, cs_n, be_s, wd_s, wr_s);
    check("post_reset_rdata", rdata, 32'h0102_0304);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
